// File: rtl/wb_stage_pkg.sv
// ==========================================================================
// wb_stage_pkg : shared widths, write-back encodings and load funct3 codes.  Rev 1.0
// ==========================================================================
`default_nettype none

package wb_stage_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int RD_WIDTH   = 5;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_LOAD = 2'b01;
  localparam logic [1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [1:0] WB_SEL_RSVD = 2'b11;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_READY     = 2'd2
  } wb_state_e;

endpackage

`default_nettype wire

// File: rtl/wb_stage_load_ext.sv
// ==========================================================================
// load_ext : selects and sign/zero-extends the byte/half/word of a load.  Rev 1.0
// ==========================================================================
`default_nettype none

module load_ext #(
  parameter int DATA_WIDTH = wb_stage_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] i_raw,
  input  logic [1:0]            i_addr,
  input  logic [2:0]            i_funct3,
  output logic [DATA_WIDTH-1:0] o_ext
);
  import wb_stage_pkg::*;

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_raw[7:0];
    case (i_addr)
      2'd1:    w_byte = i_raw[15:8];
      2'd2:    w_byte = i_raw[23:16];
      2'd3:    w_byte = i_raw[31:24];
      default: w_byte = i_raw[7:0];
    endcase
    // Halfword lane comes from addr[1] only; a misaligned addr[0] is ignored.
    w_half = i_addr[1] ? i_raw[31:16] : i_raw[15:0];

    o_ext = i_raw;
    case (i_funct3)
      LD_LB:   o_ext = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      LD_LH:   o_ext = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      LD_LBU:  o_ext = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      LD_LHU:  o_ext = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: o_ext = i_raw;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// ==========================================================================
// wb_stage : write-back stage holding one instruction, merging load data.  Rev 1.0
// ==========================================================================
`default_nettype none

module wb_stage #(
  parameter int DATA_WIDTH = wb_stage_pkg::DATA_WIDTH,
  parameter int RD_WIDTH   = wb_stage_pkg::RD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_mem,
  output logic                  allow_in_wb,
  input  logic                  mem_we,
  input  logic [RD_WIDTH-1:0]   mem_rd,
  input  logic [1:0]            mem_wb_sel,
  input  logic [DATA_WIDTH-1:0] mem_alu_result,
  input  logic [DATA_WIDTH-1:0] mem_pc,
  input  logic [2:0]            mem_load_type,
  input  logic                  rdata_valid,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  allow_in_regfile,
  output logic                  we,
  output logic [RD_WIDTH-1:0]   wa,
  output logic [DATA_WIDTH-1:0] wd,
  output logic                  valid_wb,
  output logic                  ready_go_wb,
  output logic                  wb_pending_load
);
  import wb_stage_pkg::*;

  wb_state_e             r_state;
  wb_state_e             w_state_next;
  logic                  r_we;
  logic [RD_WIDTH-1:0]   r_rd;
  logic [1:0]            r_wb_sel;
  logic [DATA_WIDTH-1:0] r_alu;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [2:0]            r_load_type;
  logic [DATA_WIDTH-1:0] r_load_data;
  logic [DATA_WIDTH-1:0] w_ext;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_retire;
  logic                  w_accept;
  logic                  w_capture;

  load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
    .i_raw    (rdata),
    .i_addr   (r_alu[1:0]),
    .i_funct3 (r_load_type),
    .o_ext    (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_next;
  end

  always_comb begin
    valid_wb        = (r_state != ST_EMPTY);
    wb_pending_load = (r_state == ST_WAIT_LOAD);
    ready_go_wb     = (r_state == ST_READY) || (wb_pending_load && rdata_valid);
    w_retire        = ready_go_wb && allow_in_regfile;
    allow_in_wb     = !valid_wb || w_retire;
    w_accept        = valid_mem && allow_in_wb;
    w_capture       = wb_pending_load && rdata_valid && !w_retire;

    w_state_next = r_state;
    if (w_accept)       w_state_next = (mem_wb_sel == WB_SEL_LOAD) ? ST_WAIT_LOAD : ST_READY;
    else if (w_retire)  w_state_next = ST_EMPTY;
    else if (w_capture) w_state_next = ST_READY;

    // While the load is outstanding the response is forwarded straight through.
    case (r_wb_sel)
      WB_SEL_LOAD: w_sel_data = wb_pending_load ? w_ext : r_load_data;
      WB_SEL_PC4:  w_sel_data = r_pc + DATA_WIDTH'(4);
      default:     w_sel_data = r_alu;
    endcase

    we = w_retire && r_we && (r_rd != '0);
    wa = valid_wb ? r_rd : '0;
    wd = valid_wb ? w_sel_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_rd        <= '0;
      r_wb_sel    <= WB_SEL_ALU;
      r_alu       <= '0;
      r_pc        <= '0;
      r_load_type <= LD_LW;
      r_load_data <= '0;
    end else if (w_accept) begin
      r_we        <= mem_we;
      r_rd        <= mem_rd;
      r_wb_sel    <= mem_wb_sel;
      r_alu       <= mem_alu_result;
      r_pc        <= mem_pc;
      r_load_type <= mem_load_type;
    end else if (w_capture) begin
      r_load_data <= w_ext;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ==========================================================================
// tb_wb_stage : directed scoreboard bench for wb_stage.  Rev 1.0
// ==========================================================================
`default_nettype none

module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_mem;
  logic        allow_in_wb;
  logic        mem_we;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc;
  logic [2:0]  mem_load_type;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        allow_in_regfile;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        valid_wb;
  logic        ready_go_wb;
  logic        wb_pending_load;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_wr   = 0;
  int n_push = 0;
  logic [36:0] exp_q[$];

  wb_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_mem        (valid_mem),
    .allow_in_wb      (allow_in_wb),
    .mem_we           (mem_we),
    .mem_rd           (mem_rd),
    .mem_wb_sel       (mem_wb_sel),
    .mem_alu_result   (mem_alu_result),
    .mem_pc           (mem_pc),
    .mem_load_type    (mem_load_type),
    .rdata_valid      (rdata_valid),
    .rdata            (rdata),
    .allow_in_regfile (allow_in_regfile),
    .we               (we),
    .wa               (wa),
    .wd               (wd),
    .valid_wb         (valid_wb),
    .ready_go_wb      (ready_go_wb),
    .wb_pending_load  (wb_pending_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
    n_push++;
  endtask

  task automatic issue(input logic w, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] lt);
    valid_mem      = 1'b1;
    mem_we         = w;
    mem_rd         = rd;
    mem_wb_sel     = sel;
    mem_alu_result = alu;
    mem_pc         = pc;
    mem_load_type  = lt;
    @(posedge clk); #1;
    valid_mem      = 1'b0;
  endtask

  // Monitor: every register-file write must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [36:0] e;
    if (rst_n === 1'b1 && we === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got wa=%0d wd=%h want no write", wa, wd);
      end else begin
        e = exp_q.pop_front();
        chk("write_wa", 32'(wa), 32'(e[36:32]));
        chk("write_wd", wd, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int c;
    logic acc;
    rst_n = 1'b0; valid_mem = 1'b0; mem_we = 1'b0; mem_rd = '0; mem_wb_sel = '0;
    mem_alu_result = '0; mem_pc = '0; mem_load_type = '0; rdata_valid = 1'b0;
    rdata = '0; allow_in_regfile = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(valid_wb), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_wa", 32'(wa), 0);
    chk("rst_wd", wd, 0);
    chk("rst_ready", 32'(ready_go_wb), 0);
    chk("rst_pend", 32'(wb_pending_load), 0);
    chk("rst_allow", 32'(allow_in_wb), 1);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD rd=5
    expect_write(5'd5, 32'h0000_1234);
    issue(1'b1, 5'd5, 2'b00, 32'h0000_1234, 32'h40, 3'b000);
    @(negedge clk);
    chk("add_we", 32'(we), 1);
    chk("add_allow", 32'(allow_in_wb), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("add_retired", 32'(valid_wb), 0);

    // LB addr[1:0]=11, response after three waiting cycles
    @(posedge clk); #1;
    expect_write(5'd7, 32'hFFFF_FF80);
    issue(1'b1, 5'd7, 2'b01, 32'h0000_1003, 32'h44, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lb_pend", 32'(wb_pending_load), 1);
      chk("lb_allow", 32'(allow_in_wb), 0);
      chk("lb_we_wait", 32'(we), 0);
      @(posedge clk); #1;
    end
    rdata_valid = 1'b1; rdata = 32'h80FF_FF00;
    @(negedge clk);
    chk("lb_we", 32'(we), 1);
    chk("lb_ready", 32'(ready_go_wb), 1);
    @(posedge clk); #1; rdata_valid = 1'b0;
    @(negedge clk);
    chk("lb_retired", 32'(valid_wb), 0);

    // LHU pass-through, then LH captured while the regfile stalls
    @(posedge clk); #1;
    expect_write(5'd8, 32'h0000_BEEF);
    issue(1'b1, 5'd8, 2'b01, 32'h0000_2002, 32'h0, 3'b101);
    rdata_valid = 1'b1; rdata = 32'hBEEF_0000;
    @(negedge clk);
    chk("lhu_we", 32'(we), 1);
    @(posedge clk); #1; rdata_valid = 1'b0;
    expect_write(5'd9, 32'hFFFF_BEEF);
    issue(1'b1, 5'd9, 2'b01, 32'h0000_2002, 32'h0, 3'b001);
    allow_in_regfile = 1'b0; rdata_valid = 1'b1; rdata = 32'hBEEF_0000;
    @(negedge clk);
    chk("lh_we_stall", 32'(we), 0);
    @(posedge clk); #1; rdata_valid = 1'b0; rdata = 32'h0;
    @(negedge clk);
    chk("lh_pend_after_cap", 32'(wb_pending_load), 0);
    chk("lh_ready_after_cap", 32'(ready_go_wb), 1);
    @(posedge clk); #1; allow_in_regfile = 1'b1;
    @(negedge clk);
    chk("lh_we", 32'(we), 1);
    @(posedge clk); #1;

    // LBU byte 1, and an undefined funct3 behaving as LW
    expect_write(5'd14, 32'h0000_0056);
    issue(1'b1, 5'd14, 2'b01, 32'h0000_0301, 32'h0, 3'b100);
    rdata_valid = 1'b1; rdata = 32'h1234_5678;
    @(posedge clk); #1;
    expect_write(5'd15, 32'h1234_5678);
    issue(1'b1, 5'd15, 2'b01, 32'h0000_0301, 32'h0, 3'b011);
    @(posedge clk); #1; rdata_valid = 1'b0;

    // JAL with PC wrap, then with rd=0
    expect_write(5'd1, 32'h0000_0000);
    issue(1'b1, 5'd1, 2'b10, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 3'b000);
    @(negedge clk);
    chk("jal_we", 32'(we), 1);
    @(posedge clk); #1;
    issue(1'b1, 5'd0, 2'b10, 32'h0, 32'h0000_0100, 3'b000);
    @(negedge clk);
    chk("jal_x0_we", 32'(we), 0);
    chk("jal_x0_wd", wd, 32'h0000_0104);
    chk("jal_x0_ready", 32'(ready_go_wb), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("jal_x0_retired", 32'(valid_wb), 0);

    // Reserved wb_sel selects ALU; mem_we=0 never writes
    @(posedge clk); #1;
    expect_write(5'd3, 32'h0000_CAFE);
    issue(1'b1, 5'd3, 2'b11, 32'h0000_CAFE, 32'h200, 3'b000);
    issue(1'b0, 5'd4, 2'b00, 32'h0000_1111, 32'h204, 3'b000);
    @(negedge clk);
    chk("nowe_we", 32'(we), 0);
    @(posedge clk); #1;

    // Four back-to-back ADDs with a regfile stall in cycle 2
    for (int i = 0; i < 4; i++) expect_write(5'(10 + i), 32'hA0 + 32'(i));
    idx = 0; c = 0;
    while (idx < 4 && c < 20) begin
      allow_in_regfile = (c != 2);
      valid_mem = 1'b1; mem_we = 1'b1; mem_rd = 5'(10 + idx); mem_wb_sel = 2'b00;
      mem_alu_result = 32'hA0 + 32'(idx); mem_pc = 32'h300; mem_load_type = 3'b000;
      @(negedge clk);
      if (c == 2) begin
        chk("b2b_stall_allow", 32'(allow_in_wb), 0);
        chk("b2b_stall_we", 32'(we), 0);
      end
      acc = allow_in_wb;
      @(posedge clk); #1;
      if (acc) idx++;
      c++;
    end
    valid_mem = 1'b0; allow_in_regfile = 1'b1;
    chk("b2b_issued", 32'(idx), 4);
    chk("b2b_cycles", 32'(c), 5);
    @(negedge clk);
    @(posedge clk); #1;

    // Reset while a load is outstanding; a late response must be ignored
    issue(1'b1, 5'd12, 2'b01, 32'h0000_0000, 32'h400, 3'b010);
    @(negedge clk);
    chk("rstld_pend", 32'(wb_pending_load), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstld_valid", 32'(valid_wb), 0);
    chk("rstld_pend0", 32'(wb_pending_load), 0);
    chk("rstld_allow", 32'(allow_in_wb), 1);
    chk("rstld_wd", wd, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; rdata_valid = 1'b1; rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rstld_late_we", 32'(we), 0);
    chk("rstld_late_valid", 32'(valid_wb), 0);
    @(posedge clk); #1; rdata_valid = 1'b0;
    @(negedge clk);
    chk("rstld_after_valid", 32'(valid_wb), 0);

    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("write_count", 32'(n_wr), 32'(n_push));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DATA_WIDTH, 32, datapath width; taken from `DATA_WIDTH in include.v.
REQ-002 Parameter RD_WIDTH, 5, destination register index width; taken from `RD_WIDTH in include.v.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 valid_mem  input  1  MEM stage holds a valid instruction.
REQ-006 allow_in_wb  output  1  WB can accept a new instruction this cycle.
REQ-007 mem_we  input  1  instruction writes a register.
REQ-008 mem_rd  input  RD_WIDTH  destination register index.
REQ-009 mem_wb_sel  input  2  write-data source: 00 ALU result, 01 load data, 10 PC+4, 11 reserved (treated as 00).
REQ-010 mem_alu_result  input  DATA_WIDTH  ALU result; for loads, the byte address.
REQ-011 mem_pc  input  DATA_WIDTH  instruction PC.
REQ-012 mem_load_type  input  3  RV32I load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-013 rdata_valid  input  1  data-memory read response valid, one-cycle pulse.
REQ-014 rdata  input  DATA_WIDTH  raw aligned 32-bit memory word.
REQ-015 allow_in_regfile  input  1  register file ready to accept writes.
REQ-016 we  output  1  register-file write request.
REQ-017 wa  output  RD_WIDTH  register-file write address.
REQ-018 wd  output  DATA_WIDTH  register-file write data.
REQ-019 valid_wb  output  1  WB holds a valid instruction.
REQ-020 ready_go_wb  output  1  held instruction's write data is final.
REQ-021 wb_pending_load  output  1  held instruction is a load still awaiting rdata (hazard-stall hint to ID).

Function
REQ-022 States: EMPTY (no instruction), WAIT_LOAD (load held, data outstanding), READY (data final); valid_wb=1 in WAIT_LOAD and READY.
REQ-023 Accept when valid_mem && allow_in_wb: latch we, rd, wb_sel, alu_result, pc, load_type; next state WAIT_LOAD if wb_sel=01, else READY.
REQ-024 allow_in_wb = !valid_wb || (ready_go_wb && allow_in_regfile); combinational.
REQ-025 Retire in any cycle with ready_go_wb && allow_in_regfile; with no simultaneous accept, next state EMPTY.
REQ-026 Back-to-back: retire and accept in the same cycle load the new instruction with no bubble; non-load throughput one per cycle.
REQ-027 ready_go_wb = 1 in READY; 1 in WAIT_LOAD only in a cycle with rdata_valid; 0 in EMPTY.
REQ-028 In WAIT_LOAD, rdata_valid without retire captures the extended load value and moves to READY; rdata_valid with retire writes it directly (zero-latency pass-through).
REQ-029 rdata_valid in EMPTY or READY is ignored; state and data unchanged.
REQ-030 Load extension uses alu_result[1:0]: LB/LBU byte lane addr[1:0]; LH/LHU half lane addr[1] (addr[0] ignored); LW full word; LB/LH sign-extend, LBU/LHU zero-extend; any other funct3 behaves as LW.
REQ-031 PC+4 computed modulo 2^DATA_WIDTH (0xFFFFFFFC -> 0x00000000).
REQ-032 we = valid_wb && ready_go_wb && allow_in_regfile && held_we && (held_rd != 0).
REQ-033 wa = held_rd and wd = selected data whenever valid_wb; both 0 in EMPTY.
REQ-034 wb_pending_load = 1 exactly in WAIT_LOAD.

Reset
REQ-035 rst_n low forces EMPTY, valid_wb=0, we=0, wa=0, wd=0, ready_go_wb=0, wb_pending_load=0, allow_in_wb=1, regardless of current state, including mid-WAIT_LOAD.
REQ-036 Load responses arriving after rst_n deasserts for a pre-reset load are ignored (per REQ-029).

Structure
REQ-037 wb_sel encodings, load funct3 codes, DATA_WIDTH and RD_WIDTH reside in the shared include.v.
REQ-038 One combinational sub-module, load_ext (inputs: raw word, addr[1:0], funct3; output: extended word), instantiated once.

Verification
REQ-039 ADD, rd=5, alu=0x1234, allow_in_regfile=1 -> next cycle we=1, wa=5, wd=0x1234, allow_in_wb=1.
REQ-040 LB, addr low bits=11, rdata=0x80FF_FF00 arriving 3 cycles after accept -> wb_pending_load high 3 cycles, allow_in_wb=0; then we=1, wd=0xFFFFFF80 on the rdata_valid cycle.
REQ-041 LHU, addr low bits=10, rdata=0xBEEF_0000, then LH same word -> wd=0x0000BEEF, then wd=0xFFFFBEEF.
REQ-042 JAL, rd=1, pc=0xFFFFFFFC -> wd=0x00000000; same with rd=0 -> we=0 and instruction retires.
REQ-043 Four back-to-back ADDs with allow_in_regfile low for cycle 2 -> exactly four writes in order, no duplicate, no loss, allow_in_wb=0 during the stall.
REQ-044 Reset asserted in WAIT_LOAD, rdata_valid pulsed after release -> valid_wb=0, we never asserts.
